// File: rtl/assoc_mem_pkg.sv
// Shared constants and FSM encoding for the associative search controller.
package assoc_mem_pkg;

    localparam int          DEF_ADDR_W    = 16;
    localparam int          DEF_DATA_W    = 8;
    localparam logic [15:0] DEF_LAST_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_SCAN  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/assoc_search_if.sv
// Request, memory-port and result signals of the associative search controller.
interface assoc_search_if
    import assoc_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // Handshake: Busy=0 is the only "ready"; Wr_Req/Rd_Req are sampled on a
    // rising edge only while Busy=0 and ignored otherwise, so a requester holds
    // its request until it sees Busy rise, and a search ends with a one-cycle Done.
    logic              Wr_Req;
    logic              Rd_Req;
    logic              Abort;
    logic [DATA_W-1:0] Data_In;
    logic [ADDR_W-1:0] Wr_Addr;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_WE;
    logic              Mem_RE;
    logic [DATA_W-1:0] Mem_WData;
    logic [DATA_W-1:0] Mem_RData;
    logic              Busy;
    logic              Done;
    logic              Found;
    logic [ADDR_W-1:0] Match_Addr;

    modport slave (
        input  Wr_Req, Rd_Req, Abort, Data_In, Wr_Addr, Mem_RData,
        output Mem_Addr, Mem_WE, Mem_RE, Mem_WData, Busy, Done, Found, Match_Addr
    );

    modport master (
        output Wr_Req, Rd_Req, Abort, Data_In, Wr_Addr, Mem_RData,
        input  Mem_Addr, Mem_WE, Mem_RE, Mem_WData, Busy, Done, Found, Match_Addr
    );

endinterface

// File: rtl/scan_addr_counter.sv
// Scan address counter: synchronous clear, enable, saturates at LAST_ADDR.
module scan_addr_counter #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    logic [ADDR_W-1:0] count_d;
    logic [ADDR_W-1:0] count_q;

    assign tc    = (count_q == LAST_ADDR);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/assoc_search_ctrl.sv
// Controller that writes one word or linearly scans external memory for a key,
// with a one-stage read/compare pipeline and registered Moore outputs.
module assoc_search_ctrl
    import assoc_mem_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEF_LAST_ADDR)
) (
    input  logic          Clock,
    input  logic          Reset,
    assoc_search_if.slave bus,
    output state_t        dbg_state
);

    state_t            state_q,      state_d;
    logic [DATA_W-1:0] key_q,        key_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_we_q,     mem_we_d;
    logic              mem_re_q,     mem_re_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              found_q,      found_d;
    logic [ADDR_W-1:0] match_addr_q, match_addr_d;
    logic              cmp_valid_q,  cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q,   cmp_addr_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [ADDR_W-1:0] cnt_val;
    logic              cnt_tc;
    logic              hit;

    scan_addr_counter #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_cnt (
        .clk   (Clock),
        .rst   (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt_val),
        .tc    (cnt_tc)
    );

    // Read data returned this cycle belongs to the address issued last cycle.
    assign hit = cmp_valid_q && (bus.Mem_RData == key_q);

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        mem_addr_d   = '0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_wdata_d  = '0;
        found_d      = found_q;
        match_addr_d = match_addr_q;
        cmp_valid_d  = mem_re_q;
        cmp_addr_d   = mem_addr_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Wr_Req) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.Wr_Addr;
                    mem_wdata_d = bus.Data_In;
                end else if (bus.Rd_Req) begin
                    state_d      = ST_SCAN;
                    key_d        = bus.Data_In;
                    found_d      = 1'b0;
                    match_addr_d = '0;
                    cnt_clr      = 1'b1;
                    mem_re_d     = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_SCAN: begin
                // A hit beats both Abort and the end-of-range exit.
                if (hit) begin
                    state_d      = ST_DONE;
                    found_d      = 1'b1;
                    match_addr_d = cmp_addr_q;
                end else if (bus.Abort) begin
                    state_d = ST_DONE;
                end else if (cnt_tc) begin
                    state_d = ST_FLUSH;
                end else begin
                    cnt_en     = 1'b1;
                    mem_re_d   = 1'b1;
                    mem_addr_d = cnt_val + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                if (hit) begin
                    found_d      = 1'b1;
                    match_addr_d = cmp_addr_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            match_addr_q <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
            match_addr_q <= match_addr_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
        end
    end

    assign bus.Mem_Addr   = mem_addr_q;
    assign bus.Mem_WE     = mem_we_q;
    assign bus.Mem_RE     = mem_re_q;
    assign bus.Mem_WData  = mem_wdata_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Found      = found_q;
    assign bus.Match_Addr = match_addr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_assoc_search_ctrl.sv
// Bench for assoc_search_ctrl with LAST_ADDR=15 and a small registered-read memory model.
module tb_assoc_search_ctrl;
    import assoc_mem_pkg::*;

    localparam int LAST = 15;

    logic   clk;
    logic   rst;
    logic   mem_clr;
    state_t dbg_state;

    logic [7:0]  mem     [32];
    logic [7:0]  ref_mem [16];
    logic [32:0] exp_q   [$];   // {found, match_addr[15:0], latency[7:0], re_cycles[7:0]}
    logic [23:0] exp_wr_q[$];   // {addr[15:0], data[7:0]}

    int checks;
    int fails;

    assoc_search_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    assoc_search_ctrl #(
        .ADDR_W    (16),
        .DATA_W    (8),
        .LAST_ADDR (16'h000F)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model: data valid the cycle after Mem_RE ----------------
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else begin
            if (bus.Mem_WE) mem[bus.Mem_Addr[4:0]] <= bus.Mem_WData;
            if (bus.Mem_RE) bus.Mem_RData <= mem[bus.Mem_Addr[4:0]];
        end
    end

    // ---------------- write / strobe monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((bus.Mem_WE && bus.Mem_RE) || (!bus.Mem_WE && !bus.Mem_RE && bus.Mem_Addr != 16'h0)) begin
                fails++;
                $display("FAIL strobes: WE=%b RE=%b Mem_Addr=%h, required exclusive strobes and addr 0 when idle",
                         bus.Mem_WE, bus.Mem_RE, bus.Mem_Addr);
            end
            if (bus.Mem_WE) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: addr=%h data=%h, required no write", bus.Mem_Addr, bus.Mem_WData);
                end else begin
                    logic [23:0] e;
                    e = exp_wr_q.pop_front();
                    if ({bus.Mem_Addr, bus.Mem_WData} !== e || bus.Done !== 1'b0) begin
                        fails++;
                        $display("FAIL write_txn: addr=%h data=%h done=%b, required addr=%h data=%h done=0",
                                 bus.Mem_Addr, bus.Mem_WData, bus.Done, e[23:8], e[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [32:0] model(input logic [7:0] key, input int abort_at);
        for (int a = 0; a <= LAST; a++) begin
            // compare of address a lands in cycle a+2; Abort at address n is seen in cycle n+1
            if (abort_at >= 0 && a > abort_at - 1) break;
            if (ref_mem[a] == key)
                return {1'b1, 16'(a), 8'(a + 3), 8'((a + 2 > LAST + 1) ? LAST + 1 : a + 2)};
        end
        if (abort_at >= 0) return {1'b0, 16'h0, 8'(abort_at + 2), 8'(abort_at + 1)};
        return {1'b0, 16'h0, 8'(LAST + 3), 8'(LAST + 1)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        for (int i = 0; i <= LAST; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.Wr_Req  = 1'b1;
        bus.Wr_Addr = addr;
        bus.Data_In = data;
        exp_wr_q.push_back({addr, data});
        if (addr <= 16'(LAST)) ref_mem[addr[3:0]] = data;
        @(negedge clk);
        bus.Wr_Req = 1'b0;
        checks++;
        if (dbg_state !== ST_WRITE || bus.Busy !== 1'b1) begin
            fails++;
            $display("FAIL write_state: state=%0d busy=%b, required state=%0d busy=1", dbg_state, bus.Busy, ST_WRITE);
        end
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL write_return: busy=%b done=%b, required busy=0 done=0", bus.Busy, bus.Done);
        end
    endtask

    // Cycle 0 is the cycle in which Rd_Req is presented and accepted.
    task automatic run_search(input logic [7:0] key, input int abort_at, input bit poke_wr, input string name);
        logic [32:0] e;
        int          cyc;
        int          re_cnt;
        bit          got;
        exp_q.push_back(model(key, abort_at));
        @(negedge clk);
        bus.Rd_Req  = 1'b1;
        bus.Data_In = key;
        cyc = 0; re_cnt = 0; got = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.Rd_Req  = 1'b0;
            bus.Wr_Req  = poke_wr && cyc >= 2 && cyc <= 4;
            bus.Wr_Addr = 16'h001F;
            if (cyc == 1) begin
                checks++;
                if (bus.Found !== 1'b0 || bus.Match_Addr !== 16'h0 || bus.Busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_accept: found=%b match=%h busy=%b, required 0/0000/1",
                             name, bus.Found, bus.Match_Addr, bus.Busy);
                end
            end
            if (bus.Mem_RE) re_cnt++;
            if (bus.Done) got = 1;
            else bus.Abort = (abort_at >= 0 && bus.Mem_RE && int'(bus.Mem_Addr) == abort_at);
        end
        bus.Abort  = 1'b0;
        bus.Wr_Req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: no Done within %0d cycles, required Done at cycle %0d", name, cyc, e[15:8]);
        end else begin
            if (bus.Found !== e[32] || bus.Match_Addr !== e[31:16]) begin
                fails++;
                $display("FAIL %s_result: found=%b match=%h, required found=%b match=%h",
                         name, bus.Found, bus.Match_Addr, e[32], e[31:16]);
            end
            checks++;
            if (cyc != int'(e[15:8])) begin
                fails++;
                $display("FAIL %s_latency: Done at cycle %0d, required %0d", name, cyc, e[15:8]);
            end
            checks++;
            if (re_cnt != int'(e[7:0])) begin
                fails++;
                $display("FAIL %s_re_cycles: Mem_RE high %0d cycles, required %0d", name, re_cnt, e[7:0]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Found !== e[32] || bus.Match_Addr !== e[31:16]) begin
            fails++;
            $display("FAIL %s_after: done=%b busy=%b found=%b match=%h, required 0/0/%b/%h",
                     name, bus.Done, bus.Busy, bus.Found, bus.Match_Addr, e[32], e[31:16]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.Busy, bus.Done, bus.Found, bus.Mem_WE, bus.Mem_RE, bus.Mem_Addr, bus.Match_Addr, bus.Mem_WData} !== 45'h0
            || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b found=%b we=%b re=%b addr=%h match=%h wdata=%h state=%0d, required all 0",
                     bus.Busy, bus.Done, bus.Found, bus.Mem_WE, bus.Mem_RE, bus.Mem_Addr, bus.Match_Addr, bus.Mem_WData, dbg_state);
        end
        rst = 1'b0;
        clear_mem();
    endtask

    task automatic test_write();
        do_write(16'h0010, 8'hA5);
    endtask

    task automatic test_search_hit();
        clear_mem();
        do_write(16'h0005, 8'h3C);
        run_search(8'h3C, -1, 1'b0, "hit");
    endtask

    task automatic test_miss();
        run_search(8'hFF, -1, 1'b1, "miss");
    endtask

    task automatic test_priority();
        @(negedge clk);
        bus.Wr_Req  = 1'b1;
        bus.Rd_Req  = 1'b1;
        bus.Wr_Addr = 16'h0003;
        bus.Data_In = 8'h77;
        exp_wr_q.push_back({16'h0003, 8'h77});
        ref_mem[3] = 8'h77;
        @(negedge clk);
        bus.Wr_Req = 1'b0;
        bus.Rd_Req = 1'b0;
        checks++;
        if (dbg_state !== ST_WRITE || bus.Mem_RE !== 1'b0) begin
            fails++;
            $display("FAIL priority_state: state=%0d re=%b, required state=%0d re=0", dbg_state, bus.Mem_RE, ST_WRITE);
        end
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL priority_idle: busy=%b, required 0", bus.Busy);
        end
        do_write(16'h0009, 8'h77);
        run_search(8'h77, -1, 1'b0, "dup");
    endtask

    task automatic test_hit_end();
        do_write(16'(LAST), 8'h5A);
        run_search(8'h5A, -1, 1'b0, "hit_last");
        do_write(16'(LAST - 1), 8'hC3);
        run_search(8'hC3, -1, 1'b0, "hit_prelast");
    endtask

    task automatic test_abort();
        run_search(8'h11, 4, 1'b0, "abort");
        do_write(16'h0003, 8'h22);
        run_search(8'h22, 4, 1'b0, "abort_vs_hit");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.Rd_Req  = 1'b1;
        bus.Data_In = 8'hEE;
        @(negedge clk);
        bus.Rd_Req = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.Busy, bus.Done, bus.Found, bus.Mem_WE, bus.Mem_RE, bus.Mem_Addr, bus.Match_Addr, bus.Mem_WData} !== 45'h0
            || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset_async: busy=%b re=%b addr=%h state=%0d, required all 0 before next edge",
                     bus.Busy, bus.Mem_RE, bus.Mem_Addr, dbg_state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // first request after reset must be taken on the very next edge
        bus.Wr_Req  = 1'b1;
        bus.Wr_Addr = 16'h0007;
        bus.Data_In = 8'h99;
        exp_wr_q.push_back({16'h0007, 8'h99});
        ref_mem[7] = 8'h99;
        @(negedge clk);
        bus.Wr_Req = 1'b0;
        checks++;
        if (bus.Mem_WE !== 1'b1 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_req: we=%b done=%b, required we=1 done=0", bus.Mem_WE, bus.Done);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.Done !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_done: done=%b, required 0", bus.Done);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        for (int i = 0; i <= LAST; i++) do_write(16'(i), 8'($urandom_range(0, 7)));
        for (int n = 0; n < 5; n++) run_search(8'($urandom_range(0, 9)), -1, 1'b0, "rand");
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        checks = 0; fails = 0;
        mem_clr = 1'b0;
        bus.Wr_Req = 1'b0; bus.Rd_Req = 1'b0; bus.Abort = 1'b0;
        bus.Data_In = 8'h00; bus.Wr_Addr = 16'h0000;
        for (int i = 0; i <= LAST; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_write();
        test_search_hit();
        test_miss();
        test_priority();
        test_hit_end();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_wr_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d writes and %0d searches pending, required 0", exp_wr_q.size(), exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/assoc_search_ctrl.md
ASSOC_SEARCH_CTRL -- requirements
Module: assoc_search_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width; DATA_W, default 8, data width; LAST_ADDR, default 16'hFFFF, final address scanned.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Wr_Req  input  1  write request, sampled in IDLE.
REQ-005 Rd_Req  input  1  search request, sampled in IDLE.
REQ-006 Abort  input  1  terminates an active search.
REQ-007 Data_In  input  DATA_W  write data, or search key.
REQ-008 Wr_Addr  input  ADDR_W  write target address.
REQ-009 Mem_Addr  output  ADDR_W  memory address.
REQ-010 Mem_WE  output  1  memory write strobe.
REQ-011 Mem_RE  output  1  memory read strobe.
REQ-012 Mem_WData  output  DATA_W  memory write data.
REQ-013 Mem_RData  input  DATA_W  memory read data, valid the cycle after Mem_RE.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 Done  output  1  one-cycle completion pulse for a search.
REQ-016 Found  output  1  search hit; held until the next search is accepted.
REQ-017 Match_Addr  output  ADDR_W  hit address; held with Found.

Function
REQ-018 The states SHALL be IDLE, WRITE, SCAN, FLUSH and DONE, registered and Moore-decoded.
REQ-019 In IDLE, Wr_Req=1 SHALL go to WRITE, latching Data_In and Wr_Addr; Wr_Req has priority over Rd_Req when both are high.
REQ-020 In IDLE, Rd_Req=1 with Wr_Req=0 SHALL go to SCAN, latching Data_In as the key, clearing Found and Match_Addr, and setting the scan counter to 0.
REQ-021 WRITE SHALL last exactly one cycle, with Mem_WE=1, Mem_Addr=latched address and Mem_WData=latched data, then return to IDLE; Done is not pulsed.
REQ-022 In SCAN, the block SHALL assert Mem_RE=1 and drive Mem_Addr=counter each cycle, incrementing the counter by 1.
REQ-023 The compare SHALL be pipelined one stage: in the cycle after address A is issued, Mem_RData SHALL be compared with the key and A held in a delay register.
REQ-024 A compare hit SHALL set Found=1 and Match_Addr=A, stop issuing reads, and enter DONE next cycle.
REQ-025 When LAST_ADDR has been issued with no hit, the block SHALL go to FLUSH; FLUSH SHALL compare the final read with Mem_RE=0, then enter DONE.
REQ-026 A hit on any address SHALL take priority over the LAST_ADDR exit; the first (lowest) matching address wins.
REQ-027 Worst-case search latency SHALL be LAST_ADDR+3 cycles from request acceptance to Done.
REQ-028 The counter SHALL never wrap: it stops at LAST_ADDR, and its arithmetic is ADDR_W wide.
REQ-029 Abort=1 in SCAN or FLUSH SHALL go to DONE next cycle with Found=0 and Match_Addr=0; a hit in the same cycle as Abort SHALL win.
REQ-030 DONE SHALL pulse Done=1 for one cycle, then return to IDLE; requests are ignored while Busy=1.
REQ-031 Mem_WE and Mem_RE SHALL never be high together; outside WRITE and SCAN both SHALL be 0 and Mem_Addr SHALL be 0.

Reset
REQ-032 Reset=1 SHALL immediately force IDLE, with all outputs, the counter, the key and the latches at 0.
REQ-033 Reset mid-search SHALL abandon the search with no Done pulse.
REQ-034 The first request after Reset deasserts SHALL be accepted on the next rising edge.

Structure
REQ-035 The state encoding and the default ADDR_W, DATA_W and LAST_ADDR constants SHALL live in the shared package assoc_mem_pkg.
REQ-036 The scan counter SHALL be one sub-module, scan_addr_counter, with clear, enable, terminal-count flag and async reset.
REQ-037 The compare SHALL be inline equality; no memory array exists inside this block.

Verification
REQ-038 Bench case 1, write: Wr_Req with Wr_Addr=16'h0010 and Data_In=8'hA5 -> exactly one cycle of Mem_WE=1 at 16'h0010 with 8'hA5, and Done=0 throughout.
REQ-039 Bench case 2, search hit: mem[5]=8'h3C, others 0, LAST_ADDR=16'h000F, Rd_Req key 8'h3C -> Found=1 and Match_Addr=5, with Done 8 cycles after acceptance.
REQ-040 Bench case 3, miss: LAST_ADDR=16'h000F, key 8'hFF absent -> Done at acceptance+18, Found=0, and Mem_RE high for exactly 16 cycles.
REQ-041 Bench case 4, priority and duplicates: Wr_Req and Rd_Req together -> WRITE first; mem[3]=mem[9]=8'h77 -> Match_Addr=3.
REQ-042 Bench case 5, hit at the end: a match at LAST_ADDR -> Found=1 and Match_Addr=LAST_ADDR.
REQ-043 Bench case 6, abort and reset: Abort at scan address 4 -> Done next cycle with Found=0; Reset pulsed mid-scan -> all outputs 0 asynchronously and no Done pulse.
